fp_add_arbiter: RTL

//  Shares one single-precision FP adder (32-bit A/B in, 32-bit sum + cout out) between N_REQ requesters.

---
 rtl/fp_add_arbiter_if.sv | 30 +++
 rtl/fp_add_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - request, shared-adder and response bundle for fp_add_arbiter
interface fp_add_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [32*N_REQ-1:0] req_a;
   logic [32*N_REQ-1:0] req_b;
   logic [31:0]         add_a;
   logic [31:0]         add_b;
   logic [31:0]         add_sum;
   logic                add_cout;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [31:0]         rsp_sum;
   logic                rsp_cout;
   logic                busy;

   modport slave (
      input  req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
      output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport master (
      output req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
      input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );
endinterface

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one FP adder among N_REQ requesters
module fp_add_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADD_LAT = 1,
   parameter int ID_W    = 2
) (
   input logic             clk,
   input logic             rst,
   fp_add_arbiter_if.slave bus
);
   localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      add_a_q, add_a_d;
   logic [31:0]      add_b_q, add_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [31:0]      rsp_sum_q, rsp_sum_d;
   logic             rsp_cout_q, rsp_cout_d;

   logic [ID_W:0]    cand;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_vld;

   // Search upward from rr_ptr with wrap; first valid requester wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!grant_vld && bus.req_valid[cand[ID_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               add_a_d  = bus.req_a[32*grant_idx +: 32];
               add_b_d  = bus.req_b[32*grant_idx +: 32];
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
               cnt_d    = CNT_W'(ADD_LAT-1);
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               rsp_sum_d   = bus.add_sum;
               rsp_cout_d  = bus.add_cout;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
      end
   end

   // The accept pulse exists only while waiting in IDLE.
   assign bus.req_ready = (state_q == IDLE && grant_vld)
                          ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = (state_q != IDLE);
endmodule
